// File: rtl/fp_mul_issuer_pkg.sv
// Shared types and default parameters for the fp_mul_issuer block.
//   fp32_t         : IEEE-754 single-precision bit pattern (never interpreted)
//   issuer_state_t : issue FSM encoding
//   DEF_*          : default values for the top-level parameters
package fp_mul_issuer_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } issuer_state_t;

  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TAG_W   = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/op_fifo.sv
// Synchronous show-ahead FIFO holding {op1, op2, tag} entries.
//   clk, rst     : clock, synchronous active-high reset (flushes the FIFO)
//   push, wdata  : write request and data; ignored while full
//   pop, rdata   : read request; rdata always shows the head entry
//   full, empty  : registered status flags
module op_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 68
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      // DEPTH is a power of two, so the pointer wraps on natural overflow
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/fp_mul_issuer.sv
// Issues buffered operand pairs to the FP multiplier over its start/done
// handshake and returns tagged responses downstream.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/ready/op1/op2/tag   : upstream operand channel into the FIFO
//   mul_start, op1, op2           : start pulse and held operands to multiplier
//   mul_busy, mul_done            : multiplier status / result-valid pulse
//   mul_result, mul_overflow      : multiplier product and overflow flag
//   mul_serv                      : one-cycle acknowledge of a captured result
//   rsp_valid/ready/result/overflow/timeout/tag : downstream response channel
//
// state | meaning
// IDLE  | waiting for a buffered request and a free multiplier
// WAIT  | start issued, waiting for mul_done or the timeout
// RESP  | response presented downstream until accepted
module fp_mul_issuer
  import fp_mul_issuer_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp32_t            req_op1,
  input  fp32_t            req_op2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_start,
  output fp32_t            op1,
  output fp32_t            op2,
  input  logic             mul_busy,
  input  logic             mul_done,
  input  fp32_t            mul_result,
  input  logic             mul_overflow,
  output logic             mul_serv,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output fp32_t            rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_timeout,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int unsigned DATA_W = 64 + TAG_W;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  issuer_state_t    state_q, state_d;
  fp32_t            op1_q, op1_d;
  fp32_t            op2_q, op2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mul_start_q, mul_start_d;
  logic             mul_serv_q, mul_serv_d;
  logic             rsp_valid_q, rsp_valid_d;
  fp32_t            rsp_result_q, rsp_result_d;
  logic             rsp_overflow_q, rsp_overflow_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;

  op_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_op_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req_valid),
    .wdata({req_op1, req_op2, req_tag}),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d        = state_q;
    op1_d          = op1_q;
    op2_d          = op2_q;
    tag_d          = tag_q;
    tmo_cnt_d      = tmo_cnt_q;
    mul_start_d    = 1'b0;
    mul_serv_d     = 1'b0;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_timeout_d  = rsp_timeout_q;
    fifo_pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !mul_busy) begin
          fifo_pop               = 1'b1;
          {op1_d, op2_d, tag_d}  = fifo_rdata;
          mul_start_d            = 1'b1;
          tmo_cnt_d              = '0;
          state_d                = WAIT;
        end
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // A done landing on the last allowed cycle still counts as a result.
        if (mul_done) begin
          rsp_result_d   = mul_result;
          rsp_overflow_d = mul_overflow;
          rsp_timeout_d  = 1'b0;
          rsp_valid_d    = 1'b1;
          mul_serv_d     = 1'b1;
          state_d        = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_result_d   = '0;
          rsp_overflow_d = 1'b0;
          rsp_timeout_d  = 1'b1;
          rsp_valid_d    = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      op1_q          <= '0;
      op2_q          <= '0;
      tag_q          <= '0;
      tmo_cnt_q      <= '0;
      mul_start_q    <= 1'b0;
      mul_serv_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      tag_q          <= tag_d;
      tmo_cnt_q      <= tmo_cnt_d;
      mul_start_q    <= mul_start_d;
      mul_serv_q     <= mul_serv_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_timeout_q  <= rsp_timeout_d;
    end
  end

  assign req_ready    = !fifo_full;
  assign mul_start    = mul_start_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign mul_serv     = mul_serv_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign rsp_tag      = tag_q;

endmodule

// File: tb/tb_fp_mul_issuer.sv
// Scoreboard bench for fp_mul_issuer: requests push expected responses,
// a negedge monitor checks starts, acknowledges and responses.
module tb_fp_mul_issuer;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000000;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_op1;
  logic [31:0]      req_op2;
  logic [TAG_W-1:0] req_tag;
  logic             mul_start;
  logic [31:0]      op1;
  logic [31:0]      op2;
  logic             mul_busy;
  logic             mul_done;
  logic [31:0]      mul_result;
  logic             mul_overflow;
  logic             mul_serv;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_overflow;
  logic             rsp_timeout;
  logic [TAG_W-1:0] rsp_tag;

  fp_mul_issuer #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_tag     (req_tag),
    .mul_start   (mul_start),
    .op1         (op1),
    .op2         (op2),
    .mul_busy    (mul_busy),
    .mul_done    (mul_done),
    .mul_result  (mul_result),
    .mul_overflow(mul_overflow),
    .mul_serv    (mul_serv),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_overflow(rsp_overflow),
    .rsp_timeout (rsp_timeout),
    .rsp_tag     (rsp_tag)
  );

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    int               lat;
  } req_t;

  req_t exp_q[$];
  req_t st_q[$];
  int   lat_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = -100;
  int last_start_cyc = 0;
  int start_cnt = 0;
  int serv_cnt = 0;
  int resp_norm = 0;
  bit force_done = 0;
  bit rdy_rand = 0;

  // Multiplier behaviour: products for the named vectors, a scrambled
  // pattern otherwise (the issuer must pass whatever it gets bit-exact).
  function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FA00000 && b == 32'h3FC00000) return 32'h3FF00000;
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3F800000 && b == 32'hC0C00000) return 32'hC0C00000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
    return (int'(a[30:23]) + int'(b[30:23]) - 127) > 254;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Multiplier model
  initial begin
    int cd;
    logic [31:0] ma, mb;
    cd = 0;
    ma = '0;
    mb = '0;
    mul_done = 1'b0;
    mul_result = '0;
    mul_overflow = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      mul_done = 1'b0;
      if (rst) begin
        cd = 0;
      end else if (force_done) begin
        mul_done = 1'b1;
        mul_result = 32'hDEADBEEF;
        mul_overflow = 1'b1;
        force_done = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            mul_done = 1'b1;
            mul_result = ref_product(ma, mb);
            mul_overflow = ref_ovf(ma, mb);
            done_cyc = cyc;
          end
        end
        if (mul_start && lat_q.size() != 0) begin
          int l;
          l = lat_q.pop_front();
          ma = op1;
          mb = op2;
          cd = (l >= NEVER) ? 0 : l;
        end
      end
    end
  end

  // Randomised downstream backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Monitor
  initial begin
    bit prev_start, prev_valid;
    req_t r;
    prev_start = 0;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (mul_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        chk("start_single_cycle", 64'(prev_start), 0);
        chk("start_expected_present", 64'(st_q.size() != 0), 1);
        if (st_q.size() != 0) begin
          r = st_q.pop_front();
          chk("start_op1", op1, r.a);
          chk("start_op2", op2, r.b);
        end
      end
      if (mul_serv) begin
        serv_cnt++;
        chk("serv_first_resp_cycle", {rsp_valid, prev_valid, rsp_timeout}, 3'b100);
      end
      if (rsp_valid && !prev_valid) begin
        chk("serv_on_rsp_rise", 64'(mul_serv), 64'(!rsp_timeout));
        if (rsp_timeout) chk("timeout_latency", 64'(cyc - last_start_cyc), TIMEOUT);
        else             chk("done_to_valid", 64'(cyc - done_cyc), 1);
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected_present", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          bit normal;
          r = exp_q.pop_front();
          normal = (r.lat < TIMEOUT);
          chk("rsp_result", rsp_result, normal ? ref_product(r.a, r.b) : 32'h0);
          chk("rsp_overflow", 64'(rsp_overflow), normal ? 64'(ref_ovf(r.a, r.b)) : 0);
          chk("rsp_timeout", 64'(rsp_timeout), 64'(!normal));
          chk("rsp_tag", 64'(rsp_tag), 64'(r.tag));
          chk("held_ops", {op1, op2}, {r.a, r.b});
          if (normal) resp_norm++;
        end
      end
      prev_start = mul_start;
      prev_valid = rsp_valid;
    end
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t, input int lat);
    req_t r;
    int n;
    bit ok;
    n = 0;
    ok = 0;
    r.a = a;
    r.b = b;
    r.tag = t;
    r.lat = lat;
    req_valid = 1'b1;
    req_op1 = a;
    req_op2 = b;
    req_tag = t;
    while (!ok && n < 1000) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        acc_cyc = cyc;
        exp_q.push_back(r);
        st_q.push_back(r);
        lat_q.push_back(lat);
      end
      step();
      n++;
    end
    req_valid = 1'b0;
    chk("req_accepted", 64'(ok), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    chk("drain_complete", 64'(exp_q.size()), 0);
    step();
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_mul_start", 64'(mul_start), 0);
    chk("rst_mul_serv", 64'(mul_serv), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 0);
    chk("rst_rsp_overflow", 64'(rsp_overflow), 0);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_tag", 64'(rsp_tag), 0);
  endtask

  initial begin
    int s0, v0, n, first;
    logic [31:0] a, b, hres;
    logic [TAG_W-1:0] htag;
    int lat, sel;

    rst = 1'b1;
    req_valid = 1'b0;
    req_op1 = '0;
    req_op2 = '0;
    req_tag = '0;
    mul_busy = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Two-cycle reset pulse
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    step();

    // Single directed request, latency 6
    s0 = start_cnt;
    v0 = serv_cnt;
    send_req(32'h3FA00000, 32'h3FC00000, 4'd3, 6);
    drain();
    chk("single_start_count", 64'(start_cnt - s0), 1);
    chk("single_serv_count", 64'(serv_cnt - v0), 1);
    chk("single_start_latency", 64'(last_start_cyc - acc_cyc), 2);

    // Five back-to-back requests into a 4-deep FIFO
    send_req(32'h40000000, 32'h40400000, 4'd1, 6);
    first = acc_cyc;
    send_req(32'h3F800000, 32'hC0C00000, 4'd2, 6);
    send_req($urandom, $urandom, 4'd4, 6);
    send_req($urandom, $urandom, 4'd5, 6);
    send_req($urandom, $urandom, 4'd6, 6);
    chk("burst_back_to_back", 64'(acc_cyc - first), 4);
    @(negedge clk);
    chk("burst_full_not_ready", 64'(req_ready), 0);
    step();
    rsp_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 100);
    chk("hold_valid_seen", 64'(rsp_valid), 1);
    hres = rsp_result;
    htag = rsp_tag;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 1);
      chk("hold_data", {hres, 28'(htag)}, {rsp_result, 28'(rsp_tag)});
    end
    step();
    rsp_ready = 1'b1;
    drain();

    // Busy multiplier blocks issue
    mul_busy = 1'b1;
    s0 = start_cnt;
    send_req($urandom, $urandom, 4'd7, 5);
    send_req($urandom, $urandom, 4'd8, 5);
    repeat (10) step();
    chk("busy_no_start", 64'(start_cnt - s0), 0);
    mul_busy = 1'b0;
    repeat (3) step();
    chk("busy_release_one_start", 64'(start_cnt - s0), 1);
    drain();

    // Timeout, stray done, done on the last allowed cycle, done one late
    v0 = serv_cnt;
    send_req($urandom, $urandom, 4'd9, NEVER);
    drain();
    chk("timeout_no_serv", 64'(serv_cnt - v0), 0);
    force_done = 1;
    repeat (5) step();
    chk("stray_done_no_serv", 64'(serv_cnt - v0), 0);
    chk("stray_done_no_valid", 64'(rsp_valid), 0);
    send_req($urandom, $urandom, 4'd10, TIMEOUT - 1);
    drain();
    send_req($urandom, $urandom, 4'd11, TIMEOUT);
    drain();

    // Reset while in WAIT
    s0 = start_cnt;
    send_req($urandom, $urandom, 4'd12, NEVER);
    send_req($urandom, $urandom, 4'd13, 5);
    send_req($urandom, $urandom, 4'd14, 5);
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      step();
      n++;
    end
    chk("rstwait_started", 64'(start_cnt - s0), 1);
    step();
    step();
    rst = 1'b1;
    exp_q.delete();
    st_q.delete();
    lat_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_idle_ready", 64'(req_ready), 1);
    chk("rstwait_no_start", 64'(mul_start), 0);
    chk("rstwait_no_valid", 64'(rsp_valid), 0);
    s0 = start_cnt;
    v0 = serv_cnt;
    step();
    force_done = 1;
    repeat (10) step();
    chk("rstwait_fifo_flushed", 64'(start_cnt - s0), 0);
    chk("rstwait_no_serv", 64'(serv_cnt - v0), 0);
    chk("rstwait_valid_low", 64'(rsp_valid), 0);

    // Randomised traffic with backpressure
    rdy_rand = 1;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 11);
      if (sel == 0)      lat = TIMEOUT - 1;
      else if (sel == 1) lat = TIMEOUT;
      else               lat = $urandom_range(1, 12);
      send_req(a, b, TAG_W'($urandom), lat);
      repeat ($urandom_range(0, 2)) step();
    end
    rdy_rand = 0;
    rsp_ready = 1'b1;
    drain();

    chk("serv_total", 64'(serv_cnt), 64'(resp_norm));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_mul_issuer.md
# fp_mul_issuer

Client-side initiator for the single-precision floating-point multiplier's start/done handshake. It buffers operand pairs from an upstream producer in a small FIFO and issues them one at a time to the multiplier. It then captures each result and overflow flag, acknowledges the multiplier, and returns a tagged response downstream over a valid/ready channel. It sits between the datapath sequencer and the multiplier, and is the only block that drives `mul_start`, `op1`, `op2` and `mul_serv`.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the request tag returned with each response.
- `TIMEOUT`, 64: WAIT cycles allowed before a request is abandoned; ≥2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  upstream operand pair valid.
- `req_ready`  out  1  FIFO not full.
- `req_op1`, `req_op2`  in  32  IEEE-754 single operands.
- `req_tag`  in  TAG_W  caller tag.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `op1`, `op2`  out  32  operands to the multiplier, held from start until the response is released.
- `mul_busy`  in  1  multiplier occupied.
- `mul_done`  in  1  one-cycle result-valid pulse.
- `mul_result`  in  32  product, valid with `mul_done`.
- `mul_overflow`  in  1  overflow flag, valid with `mul_done`.
- `mul_serv`  out  1  one-cycle acknowledge of a captured result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  downstream accepts the response.
- `rsp_result`  out  32  captured product, or 0 on timeout.
- `rsp_overflow`  out  1  captured overflow flag.
- `rsp_timeout`  out  1  request abandoned.
- `rsp_tag`  out  TAG_W  tag of the request.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - When the FIFO is non-empty and `mul_busy`=0: pop the head into `op1`, `op2` and the tag register, register `mul_start`=1, clear the timeout counter, go to WAIT.
  - When `mul_busy`=1: stay in IDLE and do not pop.
- **WAIT**
  - `mul_start` is high only in the first WAIT cycle.
  - The counter increments every WAIT cycle.
  - `mul_done`=1: capture `mul_result` and `mul_overflow`, clear the timeout flag, go to RESP.
  - Counter = TIMEOUT-1 and `mul_done`=0: set result 0, overflow 0, timeout 1, go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - `mul_serv`=1 in the first RESP cycle only, and only if the response was not a timeout.
  - On `rsp_valid` && `rsp_ready`, go to IDLE.
- FIFO push on `req_valid` && `req_ready`. Push and pop can occur in the same cycle, including when full; when full, `req_ready`=0 so no push occurs. Pointers use DEPTH-modulo wrap; the count is $clog2(DEPTH)+1 bits.
- `mul_done` seen in IDLE or RESP (late or spurious) is ignored; no state or output changes.
- `mul_done` in the same cycle the counter reaches TIMEOUT-1: done wins, timeout=0.
- No arithmetic is performed on operands or results; they pass through bit-exact.

## Timing
- Reset values: state IDLE, FIFO empty, `req_ready`=1, `mul_start`=0, `mul_serv`=0, `rsp_valid`=0, `rsp_timeout`=0, `rsp_overflow`=0, and `op1`, `op2`, `rsp_result`, `rsp_tag` all 0.
- Request accepted in cycle N with the block idle and the FIFO empty: `mul_start` is high in N+2.
- `mul_done` in cycle M: `rsp_valid` and `mul_serv` are high in M+1.
- Back-to-back throughput: one request per (multiplier latency + 3) cycles when `rsp_ready` is held at 1.
- `rst` asserted mid-operation: next cycle the state is IDLE and the FIFO is flushed. Pulses are killed: `mul_start` is forced to 0 and no `mul_serv` is issued for the in-flight operation. A `mul_done` arriving after reset is ignored.
- All outputs are registered.

## Structure
- Package `fp_mul_issuer_pkg`:
  - `fp32_t` (logic [31:0]).
  - `issuer_state_t` enum {IDLE, WAIT, RESP}.
  - Default-parameter constants.
- Sub-module `op_fifo`: synchronous FIFO of {op1, op2, tag}, DEPTH deep, providing full/empty and push/pop. The FSM and timeout counter stay in the top level.

## Test plan
- Reset, then pulse `rst` for 2 cycles: every output is at its reset value and `req_ready`=1.
- Request 0x3FA00000 × 0x3FC00000 with tag 3; model returns 0x3FF00000 after 6 cycles: `mul_start` pulses once at N+2 with `op1`/`op2` stable; `mul_serv` pulses once; `rsp_result`=0x3FF00000, `rsp_tag`=3, `rsp_timeout`=0.
- Push 5 requests back-to-back (2.0×3.0=0x40C00000, 1.0×-6.0=0xC0C00000, and others) with DEPTH=4:
  - `req_ready` drops once 4 are buffered.
  - Responses return in order with correct tags.
  - Check again while holding `rsp_ready`=0 for 3 cycles: `rsp_valid` and the response data hold stable.
- `mul_busy`=1 for 10 cycles with the FIFO non-empty: no `mul_start` is issued, then exactly one start follows release.
- Model never asserts `mul_done`: at TIMEOUT cycles, `rsp_timeout`=1, `rsp_result`=0 and no `mul_serv`. A later stray `mul_done` is ignored. Also drive `mul_done` exactly on cycle TIMEOUT-1: a normal response with timeout=0.
- Assert `rst` in WAIT: IDLE next cycle, FIFO flushed, no response produced, and a `mul_done` pulse 2 cycles later is ignored.
